// File: rtl/bp_be_cache_req_arbiter.sv
// Shares one LCE cache-request channel between the I$ (index 0) and D$ (index 1) miss paths.
// Define BP_BE_CACHE_REQ_ARB_RR_EN for round-robin tie-breaking; otherwise D$ wins every tie.
module bp_be_cache_req_arbiter #(
    parameter int req_width_p      = 64,
    parameter int metadata_width_p = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [2*req_width_p-1:0]      req_i,
    input  logic [1:0]                    req_v_i,
    output logic [1:0]                    req_yumi_o,
    input  logic [2*metadata_width_p-1:0] metadata_i,
    input  logic [1:0]                    metadata_v_i,
    output logic [1:0]                    complete_o,
    output logic [req_width_p-1:0]        cache_req_o,
    output logic                          cache_req_v_o,
    input  logic                          cache_req_ready_i,
    output logic [metadata_width_p-1:0]   cache_req_metadata_o,
    output logic                          cache_req_metadata_v_o,
    input  logic                          cache_req_complete_i,
    output logic                          owner_o,
    output logic                          busy_o,
    output logic                          protocol_err_o
);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        WAIT_META     = 2'd1,
        WAIT_COMPLETE = 2'd2
    } state_e;

    state_e state_r, state_n;
    logic   owner_r, owner_n;
    logic   ptr_r, ptr_n;
    logic   lock_v_r, lock_v_n;
    logic   lock_idx_r;
    logic   err_r, err_n;

    logic   grant;
    logic   tie_winner;
    logic   owner_meta_v;
    logic   other_meta_v;

    // A stalled request keeps its grant so the LCE never sees the packet change under it.
    always_comb begin
`ifdef BP_BE_CACHE_REQ_ARB_RR_EN
        tie_winner = ~ptr_r;
`else
        tie_winner = 1'b1;
`endif
        if (lock_v_r) begin
            grant = lock_idx_r;
        end else if (req_v_i == 2'b11) begin
            grant = tie_winner;
        end else begin
            grant = req_v_i[1];
        end
    end

    assign owner_meta_v = metadata_v_i[owner_r];
    assign other_meta_v = metadata_v_i[~owner_r];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= IDLE;
            owner_r    <= 1'b1;
            ptr_r      <= 1'b1;
            lock_v_r   <= 1'b0;
            lock_idx_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            owner_r    <= owner_n;
            ptr_r      <= ptr_n;
            lock_v_r   <= lock_v_n;
            lock_idx_r <= grant;
            err_r      <= err_n;
        end
    end

    always_comb begin
        state_n  = state_r;
        owner_n  = owner_r;
        ptr_n    = ptr_r;
        lock_v_n = 1'b0;
        err_n    = err_r;
        case (state_r)
            IDLE: begin
                if (req_v_i[grant]) begin
                    if (cache_req_ready_i) begin
                        state_n = WAIT_META;
                        owner_n = grant;
                    end else begin
                        lock_v_n = 1'b1;
                    end
                end
                if (cache_req_complete_i) begin
                    err_n = 1'b1;
                end
            end
            WAIT_META: begin
                if (other_meta_v) begin
                    err_n = 1'b1;
                end
                if (owner_meta_v) begin
                    if (cache_req_complete_i) begin
                        state_n = IDLE;
                        ptr_n   = owner_r;
                    end else begin
                        state_n = WAIT_COMPLETE;
                    end
                end else if (cache_req_complete_i) begin
                    err_n = 1'b1;
                end
            end
            WAIT_COMPLETE: begin
                if (other_meta_v) begin
                    err_n = 1'b1;
                end
                if (cache_req_complete_i) begin
                    state_n = IDLE;
                    ptr_n   = owner_r;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Handshake outputs are held low while reset is asserted, independent of the inputs.
    always_comb begin
        req_yumi_o             = 2'b00;
        complete_o             = 2'b00;
        cache_req_v_o          = 1'b0;
        cache_req_metadata_v_o = 1'b0;
        cache_req_o            = grant ? req_i[2*req_width_p-1:req_width_p]
                                       : req_i[req_width_p-1:0];
        cache_req_metadata_o   = owner_r ? metadata_i[2*metadata_width_p-1:metadata_width_p]
                                         : metadata_i[metadata_width_p-1:0];
        if (reset_n_i) begin
            case (state_r)
                IDLE: begin
                    cache_req_v_o     = req_v_i[grant];
                    req_yumi_o[grant] = req_v_i[grant] & cache_req_ready_i;
                end
                WAIT_META: begin
                    cache_req_metadata_v_o = owner_meta_v;
                    complete_o[owner_r]    = owner_meta_v & cache_req_complete_i;
                end
                WAIT_COMPLETE: begin
                    complete_o[owner_r] = cache_req_complete_i;
                end
                default: begin
                end
            endcase
        end
    end

    assign owner_o        = owner_r;
    assign busy_o         = (state_r != IDLE);
    assign protocol_err_o = err_r;

endmodule
